crc32_stream: RTL and testbench

- Sequential, parametrised successor to our fixed-width combinational CRC-32 next-state logic.
- Accepts a framed byte stream of configurable word width over a valid/ready handshake, with per-byte enables for partial words.
- Keeps the running CRC internally, returns the finalised CRC plus a residue check per frame over a second valid/ready handshake.
- Sits between MAC/packet datapaths and FCS insertion/checking logic.

---
 rtl/crc32_stream.sv | 107 ++++++++++
 tb/tb_crc32_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_stream.sv
// Streaming reflected CRC-32 over a framed byte stream with per-byte enables.
// Produces the finalised CRC and a residue check per frame over a valid/ready result port.
//
// state | meaning
// IDLE  | no bytes of the current frame consumed yet; CRC seed is INIT
// RUN   | at least one non-last beat accepted; CRC seed is the stored register
module crc32_stream #(
  parameter int unsigned DATA_W  = 32,
  parameter logic [31:0] POLY    = 32'hEDB88320,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_W-1:0]     s_data_i,
  input  logic [DATA_W/8-1:0]   s_keep_i,
  input  logic                  s_last_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [31:0]           m_crc_o,
  output logic                  m_ok_o
);

  localparam int unsigned KEEP_W = DATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_seed, crc_next;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_crc_q, m_crc_d;
  logic        m_ok_q, m_ok_d;
  logic        accept;

  // Byte-serial, LSB-first CRC over the enabled lanes in ascending order.
  function automatic logic [31:0] crc_bytes(input logic [31:0]        seed,
                                            input logic [DATA_W-1:0]  data,
                                            input logic [KEEP_W-1:0]  keep);
    logic [31:0] c;
    c = seed;
    for (int k = 0; k < KEEP_W; k++) begin
      if (keep[k]) begin
        c = c ^ {24'h0, data[8*k +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  assign s_ready_o = !m_valid_q || m_ready_i;
  assign accept    = s_valid_i && s_ready_o;
  assign crc_seed  = (state_q == IDLE) ? INIT : crc_q;
  assign crc_next  = crc_bytes(crc_seed, s_data_i, s_keep_i);

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    m_valid_d = m_valid_q;
    m_crc_d   = m_crc_q;
    m_ok_d    = m_ok_q;
    if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end
    if (accept) begin
      if (s_last_i) begin
        state_d   = IDLE;
        crc_d     = INIT;
        m_valid_d = 1'b1;
        m_crc_d   = crc_next ^ XOR_OUT;
        m_ok_d    = (crc_next == RESIDUE);
      end else begin
        state_d = RUN;
        crc_d   = crc_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      m_valid_q <= 1'b0;
      m_crc_q   <= 32'h0;
      m_ok_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      m_valid_q <= m_valid_d;
      m_crc_q   <= m_crc_d;
      m_ok_q    <= m_ok_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_crc_o   = m_crc_q;
  assign m_ok_o    = m_ok_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Directed and randomized bench for crc32_stream; random frames are checked
// against a bit-serial CRC model computed over the frame's byte list.
module tb_crc32_stream;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] XOR_OUT = 32'hFFFFFFFF;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_data_i;
  logic [KEEP_W-1:0] s_keep_i;
  logic              s_last_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [31:0]       m_crc_o;
  logic              m_ok_o;

  int checks   = 0;
  int failures = 0;
  int received = 0;
  int expected_frames = 0;
  bit rand_ready = 1'b0;
  bit mon_en     = 1'b0;
  logic [32:0] exp_q[$];

  crc32_stream #(
    .DATA_W (DATA_W),
    .POLY   (POLY),
    .INIT   (INIT),
    .XOR_OUT(XOR_OUT),
    .RESIDUE(RESIDUE)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .s_data_i (s_data_i),
    .s_keep_i (s_keep_i),
    .s_last_i (s_last_i),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_crc_o  (m_crc_o),
    .m_ok_o   (m_ok_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: CRC-32 defined bit by bit over the whole frame's byte sequence.
  function automatic logic [31:0] model_raw(input logic [7:0] bytes[$]);
    logic [31:0] c;
    logic        fb;
    c = INIT;
    foreach (bytes[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ bytes[i][j];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (rand_ready) m_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  // Present one beat, wait for acceptance, return 1 unit after the accepting edge.
  task automatic send_beat(input logic [DATA_W-1:0] data, input logic [KEEP_W-1:0] keep,
                           input logic last);
    int cyc;
    s_valid_i = 1'b1;
    s_data_i  = data;
    s_keep_i  = keep;
    s_last_i  = last;
    #1;
    cyc = 0;
    while (!s_ready_o && cyc < 200) begin
      step();
      #1;
      cyc++;
    end
    if (!s_ready_o) check32("accept_timeout", 32'(s_ready_o), 32'd1);
    step();
    s_valid_i = 1'b0;
    s_data_i  = DATA_W'($urandom());
    s_keep_i  = KEEP_W'($urandom());
    s_last_i  = 1'($urandom());
  endtask

  always @(negedge clk_i) begin
    if (mon_en && rst_ni && m_valid_o && m_ready_i) begin
      logic [32:0] e;
      check32("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check32("rand_crc", m_crc_o, e[31:0]);
        check32("rand_ok", 32'(m_ok_o), 32'(e[32]));
      end
      received++;
    end
  end

  initial begin
    logic [7:0]        bytes[$];
    logic [31:0]       raw, fcs;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    int                n, idx, wait_cyc;

    rst_ni    = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    s_keep_i  = '0;
    s_last_i  = 1'b0;
    m_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check32("rst_s_ready", 32'(s_ready_o), 32'd1);
    check32("rst_m_valid", 32'(m_valid_o), 32'd0);
    check32("rst_m_crc", m_crc_o, 32'h0);
    check32("rst_m_ok", 32'(m_ok_o), 32'd0);
    rst_ni = 1'b1;
    step();

    // "123456789"
    send_beat(32'h34333231, 4'hF, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    send_beat(32'h00000039, 4'h1, 1'b1);
    check32("check_valid", 32'(m_valid_o), 32'd1);
    check32("check_crc", m_crc_o, 32'hCBF43926);
    check32("check_ok", 32'(m_ok_o), 32'd0);

    // Same payload with its FCS appended
    send_beat(32'h34333231, 4'hF, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    send_beat(32'hF4392639, 4'hF, 1'b0);
    send_beat(32'h000000CB, 4'h1, 1'b1);
    check32("fcs_valid", 32'(m_valid_o), 32'd1);
    check32("fcs_crc", m_crc_o, 32'h2144DF1C);
    check32("fcs_ok", 32'(m_ok_o), 32'd1);

    // "a" then back-to-back empty last beat from IDLE
    send_beat(32'hAABBCC61, 4'h1, 1'b1);
    check32("a_crc", m_crc_o, 32'hE8B7BE43);
    send_beat(32'h12345678, 4'h0, 1'b1);
    check32("empty_valid", 32'(m_valid_o), 32'd1);
    check32("empty_crc", m_crc_o, 32'h00000000);

    // Backpressure: result pending with m_ready low stalls the next frame
    step();
    m_ready_i = 1'b0;
    send_beat(32'h00000061, 4'h1, 1'b1);
    check32("bp_first_crc", m_crc_o, 32'hE8B7BE43);
    s_valid_i = 1'b1;
    s_data_i  = 32'h34333231;
    s_keep_i  = 4'hF;
    s_last_i  = 1'b0;
    #1;
    check32("bp_s_ready", 32'(s_ready_o), 32'd0);
    step();
    step();
    check32("bp_hold_valid", 32'(m_valid_o), 32'd1);
    check32("bp_hold_crc", m_crc_o, 32'hE8B7BE43);
    check32("bp_hold_ok", 32'(m_ok_o), 32'd0);
    check32("bp_s_ready2", 32'(s_ready_o), 32'd0);
    m_ready_i = 1'b1;
    send_beat(32'h34333231, 4'hF, 1'b0);
    check32("bp_consumed", 32'(m_valid_o), 32'd0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    send_beat(32'h00000039, 4'h1, 1'b1);
    check32("bp_second_valid", 32'(m_valid_o), 32'd1);
    check32("bp_second_crc", m_crc_o, 32'hCBF43926);

    // Reset between beat 1 and beat 2, then resend the whole frame
    step();
    send_beat(32'h34333231, 4'hF, 1'b0);
    m_ready_i = 1'b0;
    rst_ni    = 1'b0;
    #2;
    check32("midrst_m_valid", 32'(m_valid_o), 32'd0);
    check32("midrst_s_ready", 32'(s_ready_o), 32'd1);
    check32("midrst_m_crc", m_crc_o, 32'h0);
    step();
    rst_ni    = 1'b1;
    m_ready_i = 1'b1;
    step();
    send_beat(32'h34333231, 4'hF, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    send_beat(32'h00000039, 4'h1, 1'b1);
    check32("postrst_crc", m_crc_o, 32'hCBF43926);
    check32("postrst_ok", 32'(m_ok_o), 32'd0);
    step();
    step();

    // Random frames, random keep holes, valid gaps and result backpressure
    mon_en     = 1'b1;
    rand_ready = 1'b1;
    for (int f = 0; f < 60; f++) begin
      bytes.delete();
      n = $urandom_range(1, 64);
      for (int i = 0; i < n; i++) bytes.push_back(8'($urandom()));
      if ($urandom_range(0, 2) == 0) begin
        fcs = model_raw(bytes) ^ XOR_OUT;
        for (int i = 0; i < 4; i++) bytes.push_back(fcs[8*i +: 8]);
      end
      raw = model_raw(bytes);
      exp_q.push_back({raw == RESIDUE, raw ^ XOR_OUT});
      expected_frames++;
      idx = 0;
      do begin
        data = DATA_W'($urandom());
        keep = '0;
        for (int l = 0; l < KEEP_W; l++) begin
          if (idx < bytes.size() && $urandom_range(0, 3) != 0) begin
            data[8*l +: 8] = bytes[idx];
            keep[l] = 1'b1;
            idx++;
          end
        end
        last = (idx == bytes.size());
        repeat ($urandom_range(0, 2)) step();
        send_beat(data, keep, last);
      end while (!last);
    end

    rand_ready = 1'b0;
    m_ready_i  = 1'b1;
    wait_cyc   = 0;
    while (exp_q.size() != 0 && wait_cyc < 50) begin
      step();
      wait_cyc++;
    end
    step();
    check32("drain_queue", 32'(exp_q.size()), 32'd0);
    check32("frames_received", 32'(received), 32'(expected_frames));
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
